// File: rtl/hi_lo_register_unit_if.sv
// Handshake bundle between the execution unit and the HI/LO register unit.
// The execution side drives requests (master); the HI/LO unit answers (slave).
interface hi_lo_register_unit_if #(
    parameter int WIDTH = 32
);
    logic             freeze;
    logic             mdu_issue;
    logic             alu_wr_en;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH-1:0] alu_lo;
    logic             alu_overflow;
    logic             mt_en;
    logic             mt_sel;
    logic [WIDTH-1:0] mt_data;
    logic             rd_en;
    logic             rd_sel;
    logic             ovf_clear;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_stall;
    logic             mt_stall;
    logic             hilo_pending;
    logic             ovf_sticky;
    logic             timeout_err;

    modport master (
        output freeze, mdu_issue, alu_wr_en, alu_hi, alu_lo, alu_overflow,
        output mt_en, mt_sel, mt_data, rd_en, rd_sel, ovf_clear,
        input  rd_data, rd_valid, rd_stall, mt_stall,
        input  hilo_pending, ovf_sticky, timeout_err
    );

    modport slave (
        input  freeze, mdu_issue, alu_wr_en, alu_hi, alu_lo, alu_overflow,
        input  mt_en, mt_sel, mt_data, rd_en, rd_sel, ovf_clear,
        output rd_data, rd_valid, rd_stall, mt_stall,
        output hilo_pending, ovf_sticky, timeout_err
    );
endinterface

// File: rtl/hi_lo_register_unit.sv
// Architectural HI/LO pair: MULT/DIV result capture, MTHI/MTLO writes,
// MFHI/MFLO reads stalled while a multiply/divide is outstanding.
module hi_lo_register_unit #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                  clock,
    input logic                  reset,
    hi_lo_register_unit_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        TIMEOUT
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_q;
    logic             rd_valid_q;
    logic             pending_q;
    logic             ovf_q;
    logic             tmo_q;

    logic             busy;
    logic             rd_stall;
    logic             mt_stall;
    logic             rd_acc;
    logic             mt_acc;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    assign busy = (state != IDLE);

    // A result landing this cycle releases a stalled read immediately.
    assign rd_stall = bus.freeze ? bus.rd_en
                    : bus.rd_en & busy & ~bus.alu_wr_en;
    assign mt_stall = bus.freeze ? bus.mt_en
                    : bus.mt_en & (bus.alu_wr_en | busy);

    assign rd_acc = bus.rd_en & ~bus.freeze & ~rd_stall;
    assign mt_acc = bus.mt_en & ~bus.freeze & ~mt_stall;

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (bus.alu_wr_en) begin
            hi_nxt = bus.alu_hi;
            lo_nxt = bus.alu_lo;
        end else if (mt_acc) begin
            if (bus.mt_sel) hi_nxt = bus.mt_data;
            else            lo_nxt = bus.mt_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            pending_q  <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else if (bus.freeze) begin
            rd_valid_q <= 1'b0;
        end else begin
            hi         <= hi_nxt;
            lo         <= lo_nxt;
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_q <= bus.rd_sel ? hi_nxt : lo_nxt;

            if (bus.alu_wr_en & bus.alu_overflow) ovf_q <= 1'b1;
            else if (bus.ovf_clear)               ovf_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.mdu_issue) begin
                        state     <= PENDING;
                        pending_q <= 1'b1;
                        count     <= '0;
                    end
                end
                PENDING: begin
                    if (bus.alu_wr_en) begin
                        state     <= bus.mdu_issue ? PENDING : IDLE;
                        pending_q <= bus.mdu_issue;
                        count     <= '0;
                    end else if (bus.mdu_issue) begin
                        count <= '0;
                    end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
                        state <= TIMEOUT;
                        tmo_q <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                TIMEOUT: begin
                    if (bus.alu_wr_en) begin
                        state     <= bus.mdu_issue ? PENDING : IDLE;
                        pending_q <= bus.mdu_issue;
                        count     <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pending_q <= 1'b0;
                    count     <= '0;
                end
            endcase
        end
    end

    assign bus.rd_data      = rd_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_stall     = rd_stall;
    assign bus.mt_stall     = mt_stall;
    assign bus.hilo_pending = pending_q;
    assign bus.ovf_sticky   = ovf_q;
    assign bus.timeout_err  = tmo_q;
endmodule

// File: tb/tb_hi_lo_register_unit.sv
// Directed vector table plus randomized traffic checked against a
// cycle-level behavioural model of the HI/LO register unit.
module tb_hi_lo_register_unit;
    localparam int T = 4;

    typedef struct {
        bit          rst, frz, iss, wr;
        logic [31:0] ahi, alo;
        bit          aov, mt, msel;
        logic [31:0] md;
        bit          rd, rsel, oclr;
        bit          ers, ems, ev;
        logic [31:0] ed;
        bit          ep, eo, et;
    } vec_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    hi_lo_register_unit_if #(.WIDTH(32)) bus ();

    hi_lo_register_unit #(
        .WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;

    logic [31:0] m_hi, m_lo, m_data;
    bit          m_valid, m_busy, m_ovf, m_tmo;
    int          m_age;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passes++;
    endtask

    function automatic vec_t V(
        input bit rst, frz, iss, wr, input logic [31:0] ahi, alo,
        input bit aov, mt, msel, input logic [31:0] md,
        input bit rd, rsel, oclr,
        input bit ers, ems, ev, input logic [31:0] ed,
        input bit ep, eo, et);
        vec_t v;
        v.rst = rst; v.frz = frz; v.iss = iss; v.wr = wr;
        v.ahi = ahi; v.alo = alo; v.aov = aov; v.mt = mt;
        v.msel = msel; v.md = md; v.rd = rd; v.rsel = rsel;
        v.oclr = oclr; v.ers = ers; v.ems = ems; v.ev = ev;
        v.ed = ed; v.ep = ep; v.eo = eo; v.et = et;
        return v;
    endfunction

    task automatic model_step(input vec_t t, input bit rs, input bit ms);
        logic [31:0] nh, nl;
        if (t.rst) begin
            m_hi = 0; m_lo = 0; m_data = 0; m_valid = 0;
            m_busy = 0; m_age = 0; m_ovf = 0; m_tmo = 0;
        end else if (t.frz) begin
            m_valid = 0;
        end else begin
            nh = m_hi;
            nl = m_lo;
            if (t.wr) begin
                nh = t.ahi;
                nl = t.alo;
            end else if (t.mt && !ms) begin
                if (t.msel) nh = t.md;
                else        nl = t.md;
            end
            m_valid = t.rd && !rs;
            if (m_valid) m_data = t.rsel ? nh : nl;
            m_hi = nh;
            m_lo = nl;
            if (t.wr && t.aov) m_ovf = 1;
            else if (t.oclr)   m_ovf = 0;
            // A timed-out op ignores a bare re-issue until its result arrives.
            if (t.wr) begin
                m_busy = t.iss;
                m_age  = 0;
            end else if (t.iss && !(m_busy && m_age >= T)) begin
                m_busy = 1;
                m_age  = 0;
            end else if (m_busy && m_age < T) begin
                m_age++;
                if (m_age == T) m_tmo = 1;
            end
        end
    endtask

    task automatic run_cycle(input vec_t t, input bit use_tbl);
        bit rs, ms;
        reset            = t.rst;
        bus.freeze       = t.frz;
        bus.mdu_issue    = t.iss;
        bus.alu_wr_en    = t.wr;
        bus.alu_hi       = t.ahi;
        bus.alu_lo       = t.alo;
        bus.alu_overflow = t.aov;
        bus.mt_en        = t.mt;
        bus.mt_sel       = t.msel;
        bus.mt_data      = t.md;
        bus.rd_en        = t.rd;
        bus.rd_sel       = t.rsel;
        bus.ovf_clear    = t.oclr;
        #1;
        rs = t.frz ? t.rd : (t.rd && m_busy && !t.wr);
        ms = t.frz ? t.mt : (t.mt && (t.wr || m_busy));
        chk("rd_stall", 32'(bus.rd_stall), 32'(rs));
        chk("mt_stall", 32'(bus.mt_stall), 32'(ms));
        if (use_tbl) begin
            chk("tbl_rd_stall", 32'(bus.rd_stall), 32'(t.ers));
            chk("tbl_mt_stall", 32'(bus.mt_stall), 32'(t.ems));
        end
        @(posedge clock);
        #1;
        model_step(t, rs, ms);
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
        chk("rd_data", bus.rd_data, m_data);
        chk("hilo_pending", 32'(bus.hilo_pending), 32'(m_busy));
        chk("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_ovf));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
        if (use_tbl) begin
            chk("tbl_rd_valid", 32'(bus.rd_valid), 32'(t.ev));
            if (t.ev) chk("tbl_rd_data", bus.rd_data, t.ed);
            chk("tbl_pending", 32'(bus.hilo_pending), 32'(t.ep));
            chk("tbl_ovf", 32'(bus.ovf_sticky), 32'(t.eo));
            chk("tbl_timeout", 32'(bus.timeout_err), 32'(t.et));
        end
    endtask

    initial begin
        vec_t r;
        m_hi = 0; m_lo = 0; m_data = 0; m_valid = 0;
        m_busy = 0; m_age = 0; m_ovf = 0; m_tmo = 0;

        // reset, MT writes, reads, MT bypass
        tbl.push_back(V(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,1,1,32'hDEADBEEF,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,1,0,32'h12345678,1,1,0, 0,0,1,32'hDEADBEEF,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,1,32'h12345678,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,1,0,32'h0000CAFE,1,0,0, 0,0,1,32'h0000CAFE,0,0,0));
        // stalled read released by result
        tbl.push_back(V(0,0,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,1,0, 1,0,0,0,1,0,0));
        tbl.push_back(V(0,0,0,1,32'h1,32'hFFFFFFFE,0,0,0,0,1,1,0, 0,0,1,32'h1,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,1,32'hFFFFFFFE,0,0,0));
        // timeout after T unfrozen pending cycles
        tbl.push_back(V(0,0,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        for (int i = 0; i < T - 1; i++)
            tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,1,0,32'h77,0,0,0, 0,1,0,0,1,0,1));
        tbl.push_back(V(0,0,0,1,32'hA,32'hB,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,1,0, 0,0,1,32'hA,0,0,1));
        // reset mid-pending, then unpended result write
        tbl.push_back(V(0,0,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
        tbl.push_back(V(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,1,0, 0,0,1,32'h0,0,0,0));
        tbl.push_back(V(0,0,0,1,32'h5,32'h6,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,1,32'h6,0,0,0));
        // freeze holds everything including the timeout counter
        tbl.push_back(V(0,0,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(V(0,1,0,1,32'hBAD,32'hBAD,1,1,1,32'h99,1,1,0, 1,1,0,0,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
        tbl.push_back(V(0,0,0,1,32'h11,32'h22,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,1,0, 0,0,1,32'h11,0,0,1));
        // result beats MT write; overflow set beats clear
        tbl.push_back(V(0,0,0,1,32'h33,32'h44,1,1,0,32'h55,1,0,1, 0,1,1,32'h44,0,1,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,1,32'h44,0,1,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,1));
        // result and new issue together
        tbl.push_back(V(0,0,1,1,32'h1,32'h2,0,0,0,0,0,0,0, 0,0,0,0,1,0,1));
        tbl.push_back(V(0,0,0,1,32'h3,32'h4,0,0,0,0,0,0,0, 0,0,0,0,0,0,1));
        tbl.push_back(V(0,0,0,0,0,0,0,0,0,0,1,1,0, 0,0,1,32'h3,0,0,1));

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        r = V(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
        run_cycle(r, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r.rst  = ($urandom_range(0, 99) == 0);
            r.frz  = ($urandom_range(0, 7) == 0);
            r.iss  = ($urandom_range(0, 7) == 0);
            r.wr   = ($urandom_range(0, 5) == 0);
            r.ahi  = $urandom;
            r.alo  = $urandom;
            r.aov  = ($urandom_range(0, 3) == 0);
            r.mt   = ($urandom_range(0, 2) == 0);
            r.msel = 1'($urandom);
            r.md   = $urandom;
            r.rd   = 1'($urandom);
            r.rsel = 1'($urandom);
            r.oclr = ($urandom_range(0, 7) == 0);
            run_cycle(r, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
